// File: rtl/dmem_unit.sv
// Word-organised data RAM for the MEM stage: byte/half/word lanes, zero-latency loads, stores commit on the edge.
// Misaligned or illegal-type accesses are blocked and logged in a sticky error record; no backpressure.
module dmem_unit #(
  parameter int DEPTH_WORDS = 128,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_w,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      wdata_in,
  input  logic [2:0]       dmtype_in,
  output logic [31:0]      rdata_out,
  output logic             err_valid,
  output logic [31:0]      err_addr,
  output logic             err_is_store,
  output logic [7:0]       err_cnt,
  input  logic             err_clr,
  output logic [31:0]      store_cnt,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [31:0]      dbg_word
);

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             legal;
  logic             fault;
  logic             we;
  logic [31:0]      word_rd;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [3:0]       be;
  logic [31:0]      wlane;

  assign idx = addr_in[IDX_W+1:2];
  assign off = addr_in[1:0];

  always_comb begin
    legal = 1'b0;
    case (dmtype_in)
      DM_W:        legal = (off == 2'b00);
      DM_H, DM_HU: legal = ~off[0];
      DM_B, DM_BU: legal = 1'b1;
      default:     legal = 1'b0;
    endcase
  end

  assign fault = ~legal;
  assign we    = mem_w & legal;

  assign word_rd  = mem[idx];
  assign byte_sel = word_rd[8*off +: 8];
  assign half_sel = off[1] ? word_rd[31:16] : word_rd[15:0];
  assign dbg_word = mem[dbg_idx];

  always_comb begin
    rdata_out = 32'h0;
    if (!fault) begin
      case (dmtype_in)
        DM_W:    rdata_out = word_rd;
        DM_H:    rdata_out = {{16{half_sel[15]}}, half_sel};
        DM_HU:   rdata_out = {16'h0, half_sel};
        DM_B:    rdata_out = {{24{byte_sel[7]}}, byte_sel};
        DM_BU:   rdata_out = {24'h0, byte_sel};
        default: rdata_out = 32'h0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_in;
    case (dmtype_in)
      DM_H, DM_HU: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_in[15:0]}};
      end
      DM_B, DM_BU: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata_in[7:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_in;
      end
    endcase
  end

  // RAM is never cleared; the reset term only suppresses a store while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_is_store_q, err_is_store_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  // A clear on the same edge as a fault wipes the record first, then logs the new fault.
  always_comb begin
    err_valid_d    = err_clr ? 1'b0 : err_valid_q;
    err_addr_d     = err_clr ? 32'h0 : err_addr_q;
    err_is_store_d = err_clr ? 1'b0 : err_is_store_q;
    err_cnt_d      = err_clr ? 8'h0 : err_cnt_q;
    if (fault) begin
      if (!err_valid_d) begin
        err_addr_d     = addr_in;
        err_is_store_d = mem_w;
      end
      err_valid_d = 1'b1;
      if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'h1;
    end
    store_cnt_d = store_cnt_q + {31'h0, we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q    <= 1'b0;
      err_addr_q     <= 32'h0;
      err_is_store_q <= 1'b0;
      err_cnt_q      <= 8'h0;
      store_cnt_q    <= 32'h0;
    end else begin
      err_valid_q    <= err_valid_d;
      err_addr_q     <= err_addr_d;
      err_is_store_q <= err_is_store_d;
      err_cnt_q      <= err_cnt_d;
      store_cnt_q    <= store_cnt_d;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_addr     = err_addr_q;
  assign err_is_store = err_is_store_q;
  assign err_cnt      = err_cnt_q;
  assign store_cnt    = store_cnt_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit: lane merge, extension, fault logging, aliasing, async reset.
module tb_dmem_unit;

  localparam int DEPTH_WORDS = 128;
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_w;
  logic [31:0]      addr_in;
  logic [31:0]      wdata_in;
  logic [2:0]       dmtype_in;
  logic [31:0]      rdata_out;
  logic             err_valid;
  logic [31:0]      err_addr;
  logic             err_is_store;
  logic [7:0]       err_cnt;
  logic             err_clr;
  logic [31:0]      store_cnt;
  logic [IDX_W-1:0] dbg_idx;
  logic [31:0]      dbg_word;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_unit #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .mem_w(mem_w), .addr_in(addr_in), .wdata_in(wdata_in),
    .dmtype_in(dmtype_in), .rdata_out(rdata_out), .err_valid(err_valid), .err_addr(err_addr),
    .err_is_store(err_is_store), .err_cnt(err_cnt), .err_clr(err_clr), .store_cnt(store_cnt),
    .dbg_idx(dbg_idx), .dbg_word(dbg_word)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    mem_w = w; addr_in = a; wdata_in = d; dmtype_in = t;
    #1;
  endtask

  task automatic idle();
    mem_w = 1'b0; addr_in = 32'h0; wdata_in = 32'h0; dmtype_in = 3'b000; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    dbg_idx = '0;
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({err_valid, err_addr, err_is_store, err_cnt, store_cnt} !== 74'h0) begin
      n_bad++; $display("FAIL reset_state got v=%b a=%h s=%b c=%h sc=%h want all zero",
                        err_valid, err_addr, err_is_store, err_cnt, store_cnt);
    end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_word();
    drive(1'b1, 32'h10, 32'h1234_5678, 3'b000);
    cyc();
    drive(1'b0, 32'h10, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h1234_5678) begin
      n_bad++; $display("FAIL word_load got %h want 12345678", rdata_out);
    end
    n_cmp++; if (store_cnt !== 32'd1) begin
      n_bad++; $display("FAIL word_store_cnt got %0d want 1", store_cnt);
    end
  endtask

  task automatic test_byte();
    drive(1'b1, 32'h13, 32'h1111_11AB, 3'b011);
    cyc();
    drive(1'b0, 32'h10, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'hAB34_5678) begin
      n_bad++; $display("FAIL byte_merge got %h want ab345678", rdata_out);
    end
    drive(1'b0, 32'h13, 32'h0, 3'b011);
    n_cmp++; if (rdata_out !== 32'hFFFF_FFAB) begin
      n_bad++; $display("FAIL byte_signed got %h want ffffffab", rdata_out);
    end
    drive(1'b0, 32'h13, 32'h0, 3'b100);
    n_cmp++; if (rdata_out !== 32'h0000_00AB) begin
      n_bad++; $display("FAIL byte_unsigned got %h want 000000ab", rdata_out);
    end
    drive(1'b0, 32'h12, 32'h0, 3'b011);
    n_cmp++; if (rdata_out !== 32'h0000_0034) begin
      n_bad++; $display("FAIL byte_lane2 got %h want 00000034", rdata_out);
    end
    n_cmp++; if (store_cnt !== 32'd2) begin
      n_bad++; $display("FAIL byte_store_cnt got %0d want 2", store_cnt);
    end
  endtask

  task automatic test_half();
    drive(1'b1, 32'h20, 32'h0, 3'b000);
    cyc();
    drive(1'b1, 32'h22, 32'hCDEF_8001, 3'b001);
    cyc();
    idle();
    dbg_idx = 7'd8;
    drive(1'b0, 32'h20, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h8001_0000) begin
      n_bad++; $display("FAIL half_merge got %h want 80010000", rdata_out);
    end
    n_cmp++; if (dbg_word !== 32'h8001_0000) begin
      n_bad++; $display("FAIL dbg_word got %h want 80010000", dbg_word);
    end
    drive(1'b0, 32'h22, 32'h0, 3'b001);
    n_cmp++; if (rdata_out !== 32'hFFFF_8001) begin
      n_bad++; $display("FAIL half_signed got %h want ffff8001", rdata_out);
    end
    drive(1'b0, 32'h22, 32'h0, 3'b010);
    n_cmp++; if (rdata_out !== 32'h0000_8001) begin
      n_bad++; $display("FAIL half_unsigned got %h want 00008001", rdata_out);
    end
    drive(1'b0, 32'h20, 32'h0, 3'b001);
    n_cmp++; if (rdata_out !== 32'h0000_0000) begin
      n_bad++; $display("FAIL half_low got %h want 00000000", rdata_out);
    end
    n_cmp++; if (store_cnt !== 32'd4) begin
      n_bad++; $display("FAIL half_store_cnt got %0d want 4", store_cnt);
    end
  endtask

  task automatic test_fault();
    drive(1'b1, 32'h14, 32'h0BAD_F00D, 3'b000);
    cyc();
    drive(1'b1, 32'h15, 32'hDEAD_BEEF, 3'b000);
    n_cmp++; if (rdata_out !== 32'h0) begin
      n_bad++; $display("FAIL fault_rdata got %h want 0", rdata_out);
    end
    cyc();
    drive(1'b0, 32'h14, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL fault_ram_kept got %h want 0badf00d", rdata_out);
    end
    n_cmp++; if (store_cnt !== 32'd5) begin
      n_bad++; $display("FAIL fault_store_cnt got %0d want 5", store_cnt);
    end
    n_cmp++; if ({err_valid, err_addr, err_is_store, err_cnt} !== {1'b1, 32'h15, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL fault_first got v=%b a=%h s=%b c=%0d want 1/15/1/1",
                        err_valid, err_addr, err_is_store, err_cnt);
    end
    drive(1'b0, 32'h21, 32'h0, 3'b001);
    cyc();
    drive(1'b0, 32'h14, 32'h0, 3'b000);
    n_cmp++; if ({err_addr, err_is_store, err_cnt} !== {32'h15, 1'b1, 8'd2}) begin
      n_bad++; $display("FAIL fault_sticky got a=%h s=%b c=%0d want 15/1/2", err_addr, err_is_store, err_cnt);
    end
    err_clr = 1'b1;
    drive(1'b0, 32'h31, 32'h0, 3'b000);
    cyc();
    err_clr = 1'b0;
    drive(1'b0, 32'h14, 32'h0, 3'b000);
    n_cmp++; if ({err_valid, err_addr, err_is_store, err_cnt} !== {1'b1, 32'h31, 1'b0, 8'd1}) begin
      n_bad++; $display("FAIL clr_with_fault got v=%b a=%h s=%b c=%0d want 1/31/0/1",
                        err_valid, err_addr, err_is_store, err_cnt);
    end
    drive(1'b0, 32'h40, 32'h0, 3'b101);
    n_cmp++; if (rdata_out !== 32'h0) begin
      n_bad++; $display("FAIL illegal_rdata got %h want 0", rdata_out);
    end
    cyc();
    drive(1'b0, 32'h14, 32'h0, 3'b000);
    n_cmp++; if ({err_addr, err_cnt} !== {32'h31, 8'd2}) begin
      n_bad++; $display("FAIL illegal_type got a=%h c=%0d want 31/2", err_addr, err_cnt);
    end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_cmp++; if ({err_valid, err_addr, err_is_store, err_cnt} !== 42'h0) begin
      n_bad++; $display("FAIL clr_only got v=%b a=%h s=%b c=%0d want zero",
                        err_valid, err_addr, err_is_store, err_cnt);
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, 32'h2, 32'h0, 3'b000);
    for (int i = 0; i < 260; i++) cyc();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    n_cmp++; if (err_cnt !== 8'd255) begin
      n_bad++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt);
    end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h40, 32'hA5A5_A5A5, 3'b000);
    cyc();
    drive(1'b1, 32'h40, 32'h0000_0055, 3'b000);
    n_cmp++; if (rdata_out !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL same_cycle_old got %h want a5a5a5a5", rdata_out);
    end
    cyc();
    drive(1'b0, 32'h40, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h0000_0055) begin
      n_bad++; $display("FAIL same_cycle_new got %h want 00000055", rdata_out);
    end
    drive(1'b0, 32'h40 + 4 * DEPTH_WORDS, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h0000_0055) begin
      n_bad++; $display("FAIL alias_depth got %h want 00000055", rdata_out);
    end
    drive(1'b0, 32'h8000_0040, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h0000_0055) begin
      n_bad++; $display("FAIL alias_high got %h want 00000055", rdata_out);
    end
    n_cmp++; if (store_cnt !== 32'd7) begin
      n_bad++; $display("FAIL b2b_store_cnt got %0d want 7", store_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'h3, 32'h0, 3'b001);
    cyc();
    drive(1'b1, 32'h40, 32'h0000_0099, 3'b000);
    n_cmp++; if (err_cnt !== 8'd1) begin
      n_bad++; $display("FAIL pre_reset_cnt got %0d want 1", err_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({err_valid, err_addr, err_is_store, err_cnt, store_cnt} !== 74'h0) begin
      n_bad++; $display("FAIL async_clear got v=%b a=%h s=%b c=%0d sc=%0d want zero",
                        err_valid, err_addr, err_is_store, err_cnt, store_cnt);
    end
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 32'h40, 32'h0, 3'b000);
    n_cmp++; if (rdata_out !== 32'h0000_0055) begin
      n_bad++; $display("FAIL reset_store_dropped got %h want 00000055", rdata_out);
    end
    cyc();
    n_cmp++; if (store_cnt !== 32'd0) begin
      n_bad++; $display("FAIL post_reset_cnt got %0d want 0", store_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
